// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a CIC decimator: sample counting, decimation strobes, warm-up, ratio changes.
// Defining CIC_DECIM_CTRL_CLKOUT_EN enables the registered divided output clock on clk_out.
module cic_decim_ctrl #(
  parameter int  M_MAX     = 16,
  parameter int  RATIO_DEF = 10,
  parameter int  ORDER     = 3,
  localparam int RW        = $clog2(M_MAX + 1)
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [RW-1:0] ratio,
  input  logic          ratio_load,
  output logic          ce_in,
  output logic          ce_dec,
  output logic          out_valid,
  output logic          flush,
  output logic          clk_out,
  output logic [RW-1:0] ratio_act,
  output logic          cfg_err
);

  localparam int WW = $clog2(ORDER + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] phase_q, phase_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [RW-1:0] ratio_act_q, ratio_d;
  logic [RW-1:0] pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          ce_in_q, ce_in_d;
  logic          ce_dec_q, ce_dec_d;
  logic          out_valid_q, out_valid_d;
  logic          flush_q, flush_d;
  logic          cfg_err_q, cfg_err_d;

  logic load_ok;
  logic accept;
  logic wrap;

  assign load_ok = ratio_load && (ratio >= RW'(2)) && (ratio <= RW'(M_MAX));
  assign accept  = enable && in_valid;
  assign wrap    = accept && (phase_q == ratio_act_q - RW'(1));

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    warm_d      = warm_q;
    ratio_d     = ratio_act_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    ce_in_d     = 1'b0;
    ce_dec_d    = 1'b0;
    out_valid_d = 1'b0;
    flush_d     = 1'b0;
    cfg_err_d   = ratio_load && !load_ok;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        warm_d  = '0;
        if (load_ok) begin
          ratio_d    = ratio;
          pend_vld_d = 1'b0;
        end
        if (enable) state_d = WARMUP;
      end
      WARMUP, RUN: begin
        if (load_ok) begin
          pend_d     = ratio;
          pend_vld_d = 1'b1;
        end
        if (!enable) begin
          state_d = IDLE;
          phase_d = '0;
          warm_d  = '0;
          flush_d = 1'b1;
        end else begin
          ce_in_d = accept;
          if (accept) phase_d = wrap ? '0 : phase_q + RW'(1);
          if (wrap) begin
            ce_dec_d = 1'b1;
            // A pending ratio takes effect here; a load in this same cycle waits for the next wrap.
            if (pend_vld_q) begin
              ratio_d    = pend_q;
              phase_d    = '0;
              warm_d     = '0;
              flush_d    = 1'b1;
              state_d    = WARMUP;
              pend_vld_d = load_ok;
            end else if (state_q == RUN) begin
              out_valid_d = 1'b1;
            end else begin
              warm_d = warm_q + WW'(1);
              if (warm_q == WW'(ORDER - 1)) state_d = RUN;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      warm_q      <= '0;
      ratio_act_q <= RW'(RATIO_DEF);
      pend_vld_q  <= 1'b0;
      ce_in_q     <= 1'b0;
      ce_dec_q    <= 1'b0;
      out_valid_q <= 1'b0;
      flush_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      warm_q      <= warm_d;
      ratio_act_q <= ratio_d;
      pend_vld_q  <= pend_vld_d;
      ce_in_q     <= ce_in_d;
      ce_dec_q    <= ce_dec_d;
      out_valid_q <= out_valid_d;
      flush_q     <= flush_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Pending ratio value is only meaningful while pend_vld_q is set.
  always_ff @(posedge clk_in) begin
    pend_q <= pend_d;
  end

`ifdef CIC_DECIM_CTRL_CLKOUT_EN
  logic clk_out_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n) clk_out_q <= 1'b0;
    else          clk_out_q <= (state_d != IDLE) && (phase_d < (ratio_d >> 1));
  end

  assign clk_out = clk_out_q;
`else
  assign clk_out = 1'b0;
`endif

  assign ce_in     = ce_in_q;
  assign ce_dec    = ce_dec_q;
  assign out_valid = out_valid_q;
  assign flush     = flush_q;
  assign ratio_act = ratio_act_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: cadence, warm-up suppression, ratio changes, illegal loads, enable/reset.
module tb_cic_decim_ctrl;

  localparam int RW = $clog2(16 + 1);

  logic          clk_in;
  logic          reset_n;
  logic          enable;
  logic          in_valid;
  logic [RW-1:0] ratio;
  logic          ratio_load;
  logic          ce_in;
  logic          ce_dec;
  logic          out_valid;
  logic          flush;
  logic          clk_out;
  logic [RW-1:0] ratio_act;
  logic          cfg_err;

  int nvec = 0;
  int nerr = 0;
  int k    = 0;

  cic_decim_ctrl dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .ratio      (ratio),
    .ratio_load (ratio_load),
    .ce_in      (ce_in),
    .ce_dec     (ce_dec),
    .out_valid  (out_valid),
    .flush      (flush),
    .clk_out    (clk_out),
    .ratio_act  (ratio_act),
    .cfg_err    (cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_low(input string tag);
    check({tag, " ce_in"},     ce_in,     0);
    check({tag, " ce_dec"},    ce_dec,    0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " flush"},     flush,     0);
    check({tag, " cfg_err"},   cfg_err,   0);
    check({tag, " clk_out"},   clk_out,   0);
  endtask

  // Continuous in_valid: strobes at dfirst + n*dper, out_valid from ofirst, flush only at fl.
  task automatic run_to(input int kend, input int dfirst, input int dper, input int ofirst, input int fl);
    logic exp_dec;
    while (k < kend) begin
      tick();
      k++;
      exp_dec = (k >= dfirst) && (((k - dfirst) % dper) == 0);
      check($sformatf("ce_dec k=%0d", k),    ce_dec,    exp_dec);
      check($sformatf("out_valid k=%0d", k), out_valid, exp_dec && (k >= ofirst));
      check($sformatf("flush k=%0d", k),     flush,     k == fl);
      check($sformatf("ce_in k=%0d", k),     ce_in,     1);
    end
  endtask

  // in_valid high on even cycles, ratio 4: one strobe per 8 cycles, fourth strobe is the first valid.
  task automatic run_tog(input int kend);
    logic exp_dec;
    while (k < kend) begin
      in_valid = (k % 2) == 0;
      tick();
      k++;
      exp_dec = (k >= 7) && (((k - 7) % 8) == 0);
      check($sformatf("tog ce_in k=%0d", k),     ce_in,     (k % 2) == 1);
      check($sformatf("tog ce_dec k=%0d", k),    ce_dec,    exp_dec);
      check($sformatf("tog out_valid k=%0d", k), out_valid, exp_dec && (k >= 31));
      check($sformatf("tog flush k=%0d", k),     flush,     0);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    in_valid   = 1'b0;
    ratio      = '0;
    ratio_load = 1'b0;
    tick();
    tick();
    check_all_low("reset");
    check("reset ratio_act", ratio_act, 10);

    reset_n = 1'b1;
    tick();
    enable   = 1'b1;
    in_valid = 1'b1;
    tick();
    k = 0;
    check_all_low("entry");

    // Ratio 10 from reset: strobes every 10, first valid output on the 4th strobe.
    run_to(53, 10, 10, 40, -1);
    ratio      = RW'(5);
    ratio_load = 1'b1;
    run_to(54, 10, 10, 40, -1);
    ratio_load = 1'b0;
    check("pending ratio_act held", ratio_act, 10);
    run_to(59, 10, 10, 40, -1);
    check("pre-wrap ratio_act", ratio_act, 10);
    run_to(60, 60, 5, 80, 60);
    check("applied ratio_act", ratio_act, 5);
    run_to(90, 60, 5, 80, 60);

    ratio      = RW'(1);
    ratio_load = 1'b1;
    run_to(91, 60, 5, 80, -1);
    ratio      = RW'(17);
    check("cfg_err ratio=1", cfg_err, 1);
    check("ratio_act after 1", ratio_act, 5);
    run_to(92, 60, 5, 80, -1);
    ratio_load = 1'b0;
    check("cfg_err ratio=17", cfg_err, 1);
    check("ratio_act after 17", ratio_act, 5);
    run_to(93, 60, 5, 80, -1);
    check("cfg_err single pulse", cfg_err, 0);
    run_to(110, 60, 5, 80, -1);
    check("ratio_act after illegal", ratio_act, 5);

    enable   = 1'b0;
    in_valid = 1'b0;
    tick();
    check("disable flush", flush, 1);
    check("disable ce_dec", ce_dec, 0);
    check("disable ce_in", ce_in, 0);
    tick();
    check_all_low("idle");

    ratio      = RW'(4);
    ratio_load = 1'b1;
    tick();
    ratio_load = 1'b0;
    check("idle load ratio_act", ratio_act, 4);
    check("idle load cfg_err", cfg_err, 0);

    enable = 1'b1;
    tick();
    k = 0;
    run_tog(12);
    enable   = 1'b0;
    in_valid = 1'b0;
    tick();
    check("warmup drop flush", flush, 1);
    check("warmup drop ce_dec", ce_dec, 0);
    check("warmup drop ce_in", ce_in, 0);
    tick();
    check_all_low("idle2");
    check("idle2 ratio_act", ratio_act, 4);

    enable = 1'b1;
    tick();
    k = 0;
    run_tog(33);
    ratio      = RW'(6);
    ratio_load = 1'b1;
    run_tog(34);
    ratio_load = 1'b0;
    run_tog(35);

    reset_n  = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    tick();
    check_all_low("mid-run reset");
    check("mid-run reset ratio_act", ratio_act, 10);
    reset_n = 1'b1;
    tick();
    check_all_low("post reset");

    // A surviving pending 6 would flush and retime strobes at the first wrap.
    enable   = 1'b1;
    in_valid = 1'b1;
    tick();
    k = 0;
    run_to(45, 10, 10, 40, -1);
    check("post reset ratio_act", ratio_act, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
